memory_stage: RTL and testbench

MEMORY_STAGE -- requirements
Module: memory_stage

---
 rtl/memory_stage.sv | 133 +++++++++++++
 tb/tb_memory_stage.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// Memory pipeline stage: waits for the data-bus response, aligns load data and
// registers the retired instruction toward writeback.
`ifndef I_MAX
`define I_MEM_R 0
`define I_MEM_W 1
`define I_WEX   2
`define I_LB    3
`define I_LBU   4
`define I_LH    5
`define I_LHU   6
`define I_LW    7
`define I_LWL   8
`define I_LWR   9
`define I_MAX   10
`endif

module memory_stage #(
  parameter int unsigned CTRL_W = `I_MAX
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [31:0]       data_rdata,
  input  logic              data_data_ok,
  input  logic              valid_i,
  input  logic [31:0]       pc_i,
  input  logic [31:0]       inst_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [31:0]       result_i,
  input  logic [31:0]       eaddr_i,
  input  logic [31:0]       rdata2_i,
  input  logic [4:0]        waddr_i,
  output logic              ready_o,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [31:0]       pc_o,
  output logic [31:0]       inst_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [31:0]       result_o,
  output logic [4:0]        waddr_o,
  output logic [4:0]        fwd_addr,
  output logic [31:0]       fwd_data,
  output logic              fwd_ok
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;

  logic              got_r_q, got_r_d;
  logic [XLEN-1:0]   rbuf_q, rbuf_d;
  logic              valid_q;
  logic [XLEN-1:0]   pc_q, inst_q, result_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [RW-1:0]     waddr_q;

  logic            is_mem, done, capture;
  logic [XLEN-1:0] word, load_v;
  logic [1:0]      off;
  logic [7:0]      byte_v;
  logic [15:0]     half_v;
  logic [4:0]      sh_l, sh_r;
  logic            unused_c;

  assign unused_c = ^eaddr_i[31:2];

  // Handshake: a mem op retires once its response is here (live or buffered).
  assign is_mem   = ctrl_i[`I_MEM_R] | ctrl_i[`I_MEM_W];
  assign done     = ready_i && (!is_mem || data_data_ok || got_r_q);
  assign ready_o  = done || !valid_i;
  assign capture  = valid_i && is_mem && data_data_ok && !ready_i && !got_r_q;
  assign fwd_ok   = valid_i && done && ctrl_i[`I_WEX];
  assign fwd_addr = valid_i ? waddr_i : RW'(0);

  always_comb begin
    got_r_d = got_r_q;
    rbuf_d  = rbuf_q;
    if (done) begin
      got_r_d = 1'b0;
    end else if (capture) begin
      got_r_d = 1'b1;
      rbuf_d  = data_rdata;
    end
  end

  // Load alignment and LWL/LWR merge with the old rt value.
  always_comb begin
    word   = got_r_q ? rbuf_q : data_rdata;
    off    = eaddr_i[1:0];
    sh_l   = {~off, 3'b000};
    sh_r   = {off, 3'b000};
    byte_v = 8'(word >> sh_r);
    half_v = off[1] ? word[31:16] : word[15:0];
    load_v = word;
    if (ctrl_i[`I_LB])       load_v = {{24{byte_v[7]}}, byte_v};
    else if (ctrl_i[`I_LBU]) load_v = {24'h0, byte_v};
    else if (ctrl_i[`I_LH])  load_v = {{16{half_v[15]}}, half_v};
    else if (ctrl_i[`I_LHU]) load_v = {16'h0, half_v};
    else if (ctrl_i[`I_LWL]) load_v = (word << sh_l) | (rdata2_i & ~(32'hFFFF_FFFF << sh_l));
    else if (ctrl_i[`I_LWR]) load_v = (word >> sh_r) | (rdata2_i & ~(32'hFFFF_FFFF >> sh_r));
    fwd_data = ctrl_i[`I_MEM_R] ? load_v : result_i;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      got_r_q  <= 1'b0;
      rbuf_q   <= '0;
      valid_q  <= 1'b0;
      pc_q     <= '0;
      inst_q   <= '0;
      ctrl_q   <= '0;
      result_q <= '0;
      waddr_q  <= '0;
    end else begin
      got_r_q <= got_r_d;
      rbuf_q  <= rbuf_d;
      if (ready_i) begin
        valid_q  <= valid_i && done;
        pc_q     <= pc_i;
        inst_q   <= inst_i;
        ctrl_q   <= ctrl_i;
        result_q <= fwd_data;
        waddr_q  <= waddr_i;
      end
    end
  end

  assign valid_o  = valid_q;
  assign pc_o     = pc_q;
  assign inst_o   = inst_q;
  assign ctrl_o   = ctrl_q;
  assign result_o = result_q;
  assign waddr_o  = waddr_q;

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: expected writeback entries are queued at
// issue and compared when valid_o is accepted downstream.
`ifndef I_MAX
`define I_MEM_R 0
`define I_MEM_W 1
`define I_WEX   2
`define I_LB    3
`define I_LBU   4
`define I_LH    5
`define I_LHU   6
`define I_LW    7
`define I_LWL   8
`define I_LWR   9
`define I_MAX   10
`endif

module tb_memory_stage;

  localparam int unsigned CTRL_W = `I_MAX;

  typedef struct {
    logic [31:0]       pc;
    logic [31:0]       res;
    logic [4:0]        wa;
    logic [CTRL_W-1:0] ctrl;
  } exp_t;

  localparam logic [CTRL_W-1:0] C_LD   = CTRL_W'((1 << `I_MEM_R) | (1 << `I_WEX));
  localparam logic [CTRL_W-1:0] C_LW   = C_LD | CTRL_W'(1 << `I_LW);
  localparam logic [CTRL_W-1:0] C_LB   = C_LD | CTRL_W'(1 << `I_LB);
  localparam logic [CTRL_W-1:0] C_LBU  = C_LD | CTRL_W'(1 << `I_LBU);
  localparam logic [CTRL_W-1:0] C_LH   = C_LD | CTRL_W'(1 << `I_LH);
  localparam logic [CTRL_W-1:0] C_LHU  = C_LD | CTRL_W'(1 << `I_LHU);
  localparam logic [CTRL_W-1:0] C_LWL  = C_LD | CTRL_W'(1 << `I_LWL);
  localparam logic [CTRL_W-1:0] C_LWR  = C_LD | CTRL_W'(1 << `I_LWR);
  localparam logic [CTRL_W-1:0] C_SW   = CTRL_W'(1 << `I_MEM_W);
  localparam logic [CTRL_W-1:0] C_ADDU = CTRL_W'(1 << `I_WEX);

  logic              clk = 1'b0;
  logic              resetn;
  logic [31:0]       data_rdata;
  logic              data_data_ok;
  logic              valid_i;
  logic [31:0]       pc_i, inst_i, result_i, eaddr_i, rdata2_i;
  logic [CTRL_W-1:0] ctrl_i;
  logic [4:0]        waddr_i;
  logic              ready_o, ready_i;
  logic              valid_o;
  logic [31:0]       pc_o, inst_o, result_o;
  logic [CTRL_W-1:0] ctrl_o;
  logic [4:0]        waddr_o, fwd_addr;
  logic [31:0]       fwd_data;
  logic              fwd_ok;

  int          n_vec = 0;
  int          n_err = 0;
  exp_t        sb[$];
  logic [31:0] pc_cnt = 32'h0000_0400;

  always #5 clk = ~clk;

  memory_stage #(.CTRL_W(CTRL_W)) dut (
    .clk(clk), .resetn(resetn), .data_rdata(data_rdata), .data_data_ok(data_data_ok),
    .valid_i(valid_i), .pc_i(pc_i), .inst_i(inst_i), .ctrl_i(ctrl_i),
    .result_i(result_i), .eaddr_i(eaddr_i), .rdata2_i(rdata2_i), .waddr_i(waddr_i),
    .ready_o(ready_o), .ready_i(ready_i), .valid_o(valid_o), .pc_o(pc_o),
    .inst_o(inst_o), .ctrl_o(ctrl_o), .result_o(result_o), .waddr_o(waddr_o),
    .fwd_addr(fwd_addr), .fwd_data(fwd_data), .fwd_ok(fwd_ok)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Independent byte/halfword lane model for sub-word loads.
  function automatic logic [31:0] ref_sub(input int kind, input logic [31:0] w, input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = (off >= 2'd2) ? w[31:16] : w[15:0];
    case (kind)
      0:       return {{24{b[7]}}, b};
      1:       return {24'h0, b};
      2:       return {{16{h[15]}}, h};
      default: return {16'h0, h};
    endcase
  endfunction

  // Downstream acceptance: compare each registered result against the scoreboard.
  always @(negedge clk) begin
    if (resetn && valid_o && ready_i) begin
      if (sb.size() == 0) begin
        check("spurious_valid_o", 32'(valid_o), 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("wb_result", result_o, e.res);
        check("wb_pc", pc_o, e.pc);
        check("wb_waddr", 32'(waddr_o), 32'(e.wa));
        check("wb_ctrl", 32'(ctrl_o), 32'(e.ctrl));
      end
    end
  end

  task automatic run_op(input logic [CTRL_W-1:0] c, input logic [31:0] ea, input logic [31:0] rt,
                        input logic [31:0] res, input logic [31:0] rd, input logic [31:0] exp,
                        input int ok_wait, input int stall);
    logic mem;
    exp_t e;
    mem = c[`I_MEM_R] | c[`I_MEM_W];
    @(posedge clk); #1;
    valid_i      = 1'b1;
    ctrl_i       = c;
    eaddr_i      = ea;
    rdata2_i     = rt;
    result_i     = res;
    pc_i         = pc_cnt;
    inst_i       = ~pc_cnt;
    waddr_i      = pc_cnt[6:2];
    data_rdata   = rd;
    data_data_ok = mem && (ok_wait == 0);
    ready_i      = (stall == 0);
    e.pc = pc_cnt; e.res = exp; e.wa = pc_cnt[6:2]; e.ctrl = c;
    sb.push_back(e);
    pc_cnt = pc_cnt + 32'd4;
    if (mem) begin
      for (int i = 0; i < ok_wait; i++) begin
        @(negedge clk);
        check("wait_ready_o", 32'(ready_o), 32'h0);
        check("wait_valid_o", 32'(valid_o), 32'h0);
        @(posedge clk); #1;
      end
      data_data_ok = 1'b1;
      if (stall > 0) begin
        @(negedge clk);
        check("stall_ready_o", 32'(ready_o), 32'h0);
        @(posedge clk); #1;
        data_data_ok = 1'b0;
        data_rdata   = 32'hDEAD_BEEF;
        for (int i = 1; i < stall; i++) begin
          @(negedge clk);
          check("stall_valid_o", 32'(valid_o), 32'h0);
          @(posedge clk); #1;
        end
        ready_i = 1'b1;
      end
    end
    @(negedge clk);
    check("done_ready_o", 32'(ready_o), 32'h1);
    check("fwd_data", fwd_data, exp);
    check("fwd_ok", 32'(fwd_ok), 32'(c[`I_WEX]));
    check("fwd_addr", 32'(fwd_addr), 32'(waddr_i));
    @(posedge clk); #1;
    valid_i      = 1'b0;
    data_data_ok = 1'b0;
    @(negedge clk);
    check("valid_next", 32'(valid_o), 32'h1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0; valid_i = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
    pc_i = '0; inst_i = '0; ctrl_i = '0; result_i = '0; eaddr_i = '0;
    rdata2_i = '0; waddr_i = '0; ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    check("rst_valid_o", 32'(valid_o), 32'h0);
    check("rst_result_o", result_o, 32'h0);
    check("rst_pc_o", pc_o, 32'h0);
    check("rst_ready_o", 32'(ready_o), 32'h1);
    check("rst_fwd_addr", 32'(fwd_addr), 32'h0);

    run_op(C_LW,  32'h0000_1000, 32'h0, 32'h0, 32'h89AB_CDEF, 32'h89AB_CDEF, 0, 0);
    run_op(C_LB,  32'h0000_1003, 32'h0, 32'h0, 32'h8011_2233, 32'hFFFF_FF80, 0, 0);
    run_op(C_LBU, 32'h0000_1003, 32'h0, 32'h0, 32'h8011_2233, 32'h0000_0080, 0, 0);
    run_op(C_LH,  32'h0000_1002, 32'h0, 32'h0, 32'h8011_2233, 32'hFFFF_8011, 0, 0);
    run_op(C_LWL, 32'h0000_2001, 32'h1122_3344, 32'h0, 32'hAABB_CCDD, 32'hCCDD_3344, 0, 0);
    run_op(C_LWR, 32'h0000_2001, 32'h1122_3344, 32'h0, 32'hAABB_CCDD, 32'h11AA_BBCC, 0, 0);
    run_op(C_LWL, 32'h0000_2003, 32'h1122_3344, 32'h0, 32'hAABB_CCDD, 32'hAABB_CCDD, 0, 0);
    run_op(C_LWR, 32'h0000_2000, 32'h1122_3344, 32'h0, 32'hAABB_CCDD, 32'hAABB_CCDD, 0, 0);

    for (int k = 0; k < 4; k++) begin
      for (int o = 0; o < 4; o++) begin
        logic [CTRL_W-1:0] c;
        logic [31:0] w;
        c = (k == 0) ? C_LB : (k == 1) ? C_LBU : (k == 2) ? C_LH : C_LHU;
        w = 32'h80F1_7F22 ^ 32'($urandom_range(0, 32'h7F7F));
        run_op(c, 32'h0000_3000 | 32'(o), 32'h0, 32'h0, w, ref_sub(k, w, 2'(o)), o, 0);
      end
    end

    run_op(C_LW,   32'h0000_4000, 32'h0, 32'h0, 32'h1234_5678, 32'h1234_5678, 0, 3);
    run_op(C_SW,   32'h0000_4004, 32'h0, 32'hCAFE_0001, 32'h0, 32'hCAFE_0001, 4, 0);
    run_op(C_ADDU, 32'h0, 32'h0, 32'h0000_1234, 32'h0, 32'h0000_1234, 0, 0);

    // Reset while a response is buffered: it must be discarded.
    @(posedge clk); #1;
    valid_i = 1'b1; ctrl_i = C_LW; eaddr_i = 32'h0000_5000; ready_i = 1'b0;
    data_data_ok = 1'b1; data_rdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    data_data_ok = 1'b0;
    @(negedge clk);
    check("got_r_set", 32'(dut.got_r_q), 32'h1);
    #1 resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
    @(negedge clk);
    check("rst_got_r", 32'(dut.got_r_q), 32'h0);
    check("rst_mid_valid_o", 32'(valid_o), 32'h0);
    run_op(C_ADDU, 32'h0, 32'h0, 32'h0000_00AD, 32'h0, 32'h0000_00AD, 0, 0);
    run_op(C_LW,   32'h0000_6000, 32'h0, 32'h0, 32'h0BAD_F00D, 32'h0BAD_F00D, 2, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
